// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    // Canonical no-op (addi x0, x0, 0), parked in the output slot on a flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Byte distance between sequential instruction words
    localparam int unsigned PC_INC = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry skid buffer for {instr, pc} pairs. Push and pop
//               may occur in the same cycle; flush empties it and wins over
//               any push.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_instr_i,
    input  logic [XLEN-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_instr_o,
    output logic [XLEN-1:0] out_pc_o
);

    logic            full_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic            push;
    logic            pop;

    // A full entry can still accept a word if it is being drained this cycle
    assign in_ready_o = !full_q || out_ready_i;
    assign push       = in_valid_i && in_ready_o;
    assign pop        = full_q && out_ready_i;

    // Occupancy and payload storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            full_q  <= 1'b0;
        end else if (push) begin
            full_q  <= 1'b1;
            instr_q <= in_instr_i;
            pc_q    <= in_pc_i;
        end else if (pop) begin
            full_q  <= 1'b0;
        end
    end

    assign out_valid_o = full_q;
    assign out_instr_o = instr_q;
    assign out_pc_o    = pc_q;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch sequencer. Owns the PC, issues single-word requests to
//               instruction memory (req/ack, variable latency) and hands
//               {instr, pc} to decode through an output slot backed by a
//               one-entry skid buffer. Redirects flush wrong-path words,
//               including a request still in flight.
//               Optional: define FETCH_PERF_EN to add perf_fetched and
//               perf_bubbles counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            slot_valid_q, slot_valid_d;
    logic [XLEN-1:0] slot_instr_q, slot_instr_d;
    logic [XLEN-1:0] slot_pc_q, slot_pc_d;

    logic            xfer;
    logic            capture;
    logic            to_slot;
    logic            skid_push;
    logic            skid_full_nxt;
    logic            skid_valid;
    logic            skid_in_ready;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;

    assign xfer = slot_valid_q && id_ready;

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (redirect_valid),
        .in_valid_i (skid_push),
        .in_ready_o (skid_in_ready),
        .in_instr_i (imem_rdata),
        .in_pc_i    (pc_q),
        .out_valid_o(skid_valid),
        .out_ready_i(xfer),
        .out_instr_o(skid_instr),
        .out_pc_o   (skid_pc)
    );

    // Next-state, PC, request and output-slot logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        addr_d        = addr_q;
        slot_valid_d  = slot_valid_q;
        slot_instr_d  = slot_instr_q;
        slot_pc_d     = slot_pc_q;
        capture       = 1'b0;
        to_slot       = 1'b0;
        skid_push     = 1'b0;
        skid_full_nxt = skid_valid && !xfer;

        if (redirect_valid) begin
            // Wrong-path words are dropped; an unacked request must still
            // complete, so FETCH/DRAIN without ack park in DRAIN.
            pc_d         = redirect_pc & ~XLEN'(PC_INC - 1);
            slot_valid_d = 1'b0;
            slot_instr_d = XLEN'(NOP_INSTR);
            case (state_q)
                FETCH, DRAIN: state_d = imem_ack ? FETCH : DRAIN;
                default:      state_d = FETCH;
            endcase
        end else begin
            // The skid is older than any word arriving now, so it refills
            // the slot first.
            if (xfer && skid_valid) begin
                slot_valid_d = 1'b1;
                slot_instr_d = skid_instr;
                slot_pc_d    = skid_pc;
            end else if (xfer) begin
                slot_valid_d = 1'b0;
            end

            case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        capture = 1'b1;
                        pc_d    = pc_q + XLEN'(PC_INC);
                        to_slot = !slot_valid_q || (xfer && !skid_valid);
                        if (to_slot) begin
                            slot_valid_d = 1'b1;
                            slot_instr_d = imem_rdata;
                            slot_pc_d    = pc_q;
                        end
                        skid_push     = !to_slot && skid_in_ready;
                        skid_full_nxt = (skid_valid && !xfer) || skid_push;
                        state_d       = skid_full_nxt ? WAIT : FETCH;
                    end
                end
                WAIT:    if (xfer) state_d = FETCH;
                DRAIN:   if (imem_ack) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end

        // A new request starts whenever FETCH is entered or the previous
        // one completed; otherwise the address holds.
        req_d = (state_d == FETCH) || (state_d == DRAIN);
        if ((state_d == FETCH) && ((state_q != FETCH) || imem_ack)) begin
            addr_d = pc_d;
        end
    end

    // State, PC, request and output-slot registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_instr_q <= '0;
            slot_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_pc_q    <= slot_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = slot_valid_q;
    assign id_instr  = slot_instr_q;
    assign id_pc     = slot_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    // Delivered-instruction and empty-slot cycle counters, wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (xfer)          perf_fetched_q <= perf_fetched_q + 32'd1;
            if (!slot_valid_q) perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl with a
//               variable-latency instruction memory model (data = ~addr).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;

    always #5 clk = ~clk;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: acks after 'lat' cycles of a request; also checks that an
    // unacked request keeps req high and addr stable.
    initial begin : mem_model
        int          cnt;
        logic        prev_pend;
        logic [31:0] prev_addr;
        cnt = 0; prev_pend = 1'b0; prev_addr = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                cnt = 0; prev_pend = 1'b0; imem_ack = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("req_held", 32'(imem_req), 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                if (!imem_req) begin
                    cnt = 0; imem_ack = 1'b0;
                end else begin
                    if (imem_ack) cnt = 0;
                    cnt++;
                    imem_ack = (cnt >= lat);
                    if (imem_ack) imem_rdata = ~imem_addr;
                end
                prev_pend = imem_req && !imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin : stim
        // ---- reset values ----
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        reset = 1'b0;

        // ---- streaming, 1-cycle memory ----
        @(negedge clk);
        chk("s_req", 32'(imem_req), 32'd1);
        chk("s_addr0", imem_addr, 32'h0);
        chk("s_nvalid", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("s_valid0", 32'(id_valid), 32'd1);
        chk("s_pc0", id_pc, 32'h0);
        chk("s_instr0", id_instr, ~32'h0);
        chk("s_addr4", imem_addr, 32'h4);
        @(negedge clk);
        chk("s_pc4", id_pc, 32'h4);
        chk("s_addr8", imem_addr, 32'h8);
        @(negedge clk);
        chk("s_pc8", id_pc, 32'h8);
        chk("s_addr12", imem_addr, 32'hC);

        // ---- backpressure: slot holds 8, skid holds 12 ----
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req", 32'(imem_req), 32'd0);
            chk("bp_valid", 32'(id_valid), 32'd1);
            chk("bp_pc", id_pc, 32'h8);
            chk("bp_instr", id_instr, ~32'h8);
        end
        id_ready = 1'b1;
        @(negedge clk);
        chk("bp_pc12", id_pc, 32'hC);
        chk("bp_instr12", id_instr, ~32'hC);
        chk("bp_req1", 32'(imem_req), 32'd1);
        chk("bp_addr16", imem_addr, 32'h10);
        @(negedge clk);
        chk("bp_pc16", id_pc, 32'h10);
        chk("bp_addr20", imem_addr, 32'h14);

        // ---- latency 3 with redirects during outstanding requests ----
        reset = 1'b1;
        lat   = 3;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("d_addr0", imem_addr, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("d_hold0_req", 32'(imem_req), 32'd1);
        chk("d_hold0", imem_addr, 32'h0);
        chk("d_nvalid0", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("d_hold0b", imem_addr, 32'h0);
        @(negedge clk);
        chk("d_addr10", imem_addr, 32'h10);
        chk("d_nvalid1", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("d_addr10b", imem_addr, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("d_hold10", imem_addr, 32'h10);
        chk("d_hold10_req", 32'(imem_req), 32'd1);
        chk("d_nvalid2", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("d_addr40", imem_addr, 32'h40);
        chk("d_nvalid3", 32'(id_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("d_nvalid4", 32'(id_valid), 32'd0);
        lat = 1;
        @(negedge clk);
        chk("d_valid40", 32'(id_valid), 32'd1);
        chk("d_pc40", id_pc, 32'h40);
        chk("d_instr40", id_instr, ~32'h40);
        chk("d_addr44", imem_addr, 32'h44);

        // ---- redirect with same-cycle ack and transfer; unaligned target ----
        @(negedge clk);
        chk("r_pc44", id_pc, 32'h44);
        chk("r_addr48", imem_addr, 32'h48);
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("r_nvalid", 32'(id_valid), 32'd0);
        chk("r_addr100", imem_addr, 32'h100);
        chk("r_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        chk("r_valid100", 32'(id_valid), 32'd1);
        chk("r_pc100", id_pc, 32'h100);
        chk("r_instr100", id_instr, ~32'h100);
        chk("r_addr104", imem_addr, 32'h104);

        // ---- PC wrap ----
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("w_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("w_nvalid", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("w_addr_wrap", imem_addr, 32'h0);
        chk("w_pc_top", id_pc, 32'hFFFF_FFFC);
        chk("w_instr_top", id_instr, 32'h3);
        lat = 5;
        @(negedge clk);
        chk("w_pc0", id_pc, 32'h0);
        chk("w_addr4", imem_addr, 32'h4);

        // ---- reset while draining ----
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("x_drain_addr", imem_addr, 32'h4);
        chk("x_drain_req", 32'(imem_req), 32'd1);
        chk("x_drain_nvalid", 32'(id_valid), 32'd0);
        reset = 1'b1;
        lat   = 1;
        #1;
        chk("x_rst_req", 32'(imem_req), 32'd0);
        chk("x_rst_addr", imem_addr, 32'h0);
        chk("x_rst_valid", 32'(id_valid), 32'd0);
        chk("x_rst_instr", id_instr, 32'h0);
        chk("x_rst_pc", id_pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("x_req", 32'(imem_req), 32'd1);
        chk("x_addr0", imem_addr, 32'h0);
        chk("x_nvalid", 32'(id_valid), 32'd0);
        @(negedge clk);
        chk("x_valid", 32'(id_valid), 32'd1);
        chk("x_pc0", id_pc, 32'h0);
        chk("x_instr0", id_instr, ~32'h0);
        chk("x_addr4", imem_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_ctrl
`default_nettype wire
